// File: rtl/cpu_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_responder_pkg
//  Description : Shared types and constants for the CPU bus responder:
//                DMA state encoding, work-RAM / OAM DMA address constants
//                and a small work-RAM decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_bus_responder_pkg;

    // OAM DMA sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        RD    = 3'd3,
        WR    = 3'd4
    } dma_state_t;

    localparam logic [15:0] WRAM_TOP_ADDR = 16'h1FFF;
    localparam logic [15:0] OAM_DMA_ADDR  = 16'h4014;
    localparam logic [8:0]  OAM_DMA_LEN   = 9'd256;

    // True when a CPU address falls inside the mirrored work-RAM window
    function automatic logic wram_hit(input logic [15:0] addr,
                                      input logic [15:0] top);
        return (addr <= top);
    endfunction

endpackage : cpu_bus_responder_pkg
`default_nettype wire

// File: rtl/cpu_bus_responder_wram.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_responder_wram
//  Description : 2^WRAM_AW x 8 work RAM. One CPU port with asynchronous read
//                and synchronous write sharing an address, plus a second
//                asynchronous read port used by the OAM DMA engine.
//                Contents are not reset.
//  Ports       : clk        - system clock
//                cpu_addr   - CPU read/write index
//                cpu_wdata  - CPU write data (committed at posedge)
//                cpu_we     - CPU write enable
//                cpu_rdata  - CPU read data (combinational)
//                dma_addr   - DMA read index
//                dma_rdata  - DMA read data (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_bus_responder_wram #(
    parameter int WRAM_AW = 11
) (
    input  logic               clk,
    input  logic [WRAM_AW-1:0] cpu_addr,
    input  logic [7:0]         cpu_wdata,
    input  logic               cpu_we,
    output logic [7:0]         cpu_rdata,
    input  logic [WRAM_AW-1:0] dma_addr,
    output logic [7:0]         dma_rdata
);

    localparam int DEPTH = 1 << WRAM_AW;

    logic [7:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (cpu_we) begin
            mem_q[cpu_addr] <= cpu_wdata;
        end
    end

    assign cpu_rdata = mem_q[cpu_addr];
    assign dma_rdata = mem_q[dma_addr];

endmodule : cpu_bus_responder_wram
`default_nettype wire

// File: rtl/cpu_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_responder
//  Description : Target side of the CPU bus. Answers work-RAM accesses in the
//                mirrored $0000-WRAM_TOP window with zero wait states and
//                implements the OAM DMA trigger register: a CPU write there
//                halts the CPU (rdy low) and streams one 256-byte page into
//                the PPU OAM write port as alternating read/write cycles.
//  Optional    : CPU_BUS_OPEN_BUS_EN - adds an open-bus latch that answers
//                unmapped reads and out-of-range DMA pages with the last
//                value seen on the data bus.
//  Ports       : clk      - system clock, one CPU cycle per clock
//                rst_n    - asynchronous active-low reset
//                addr     - CPU address
//                data     - CPU data bus (driven only on responding reads)
//                read     - CPU read strobe
//                write    - CPU write strobe, data sampled at posedge
//                rdy      - CPU ready, low while DMA runs
//                oam_data - byte to PPU OAM
//                oam_we   - single-cycle OAM write strobe
//                dma_busy - high while DMA runs
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter int          WRAM_AW      = 11,
    parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_ADDR,
    parameter logic [15:0] WRAM_TOP     = WRAM_TOP_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    inout  wire  [7:0]  data,
    input  logic        read,
    input  logic        write,
    output logic        rdy,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic        dma_busy
);

    // Highest page whose bytes come from work RAM during DMA
    localparam logic [7:0] LAST_WRAM_PAGE = WRAM_TOP[15:8];
    localparam logic [7:0] LAST_IDX       = 8'(OAM_DMA_LEN - 9'd1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] oam_data_q, oam_data_d;
    logic       parity_q, parity_d;
    logic       align_q, align_d;     // trigger landed on an odd cycle

    logic               cpu_active;
    logic               ram_hit;
    logic               cpu_wr;
    logic               cpu_rd;
    logic               ram_we;
    logic               dma_trig;
    logic [7:0]         cpu_rdata;
    logic [7:0]         dma_rdata;
    logic [WRAM_AW-1:0] dma_addr;
    logic               page_in_wram;
    logic [7:0]         dma_byte;
    logic               drive_en;
    logic [7:0]         drive_val;

    // ------------------------------------------------------------------
    // CPU-side decode. Strobes are only honoured while no DMA is running.
    // ------------------------------------------------------------------
    assign cpu_active = (state_q == IDLE);
    assign ram_hit    = wram_hit(addr, WRAM_TOP);
    assign cpu_wr     = cpu_active & write;
    assign cpu_rd     = cpu_active & read & ~write;   // write wins a collision
    assign ram_we     = cpu_wr & ram_hit;
    assign dma_trig   = cpu_wr & (addr == DMA_REG_ADDR);

    assign dma_addr     = WRAM_AW'({page_q, idx_q});
    assign page_in_wram = (page_q <= LAST_WRAM_PAGE);

    cpu_bus_responder_wram #(
        .WRAM_AW (WRAM_AW)
    ) u_wram (
        .clk       (clk),
        .cpu_addr  (WRAM_AW'(addr)),
        .cpu_wdata (data),
        .cpu_we    (ram_we),
        .cpu_rdata (cpu_rdata),
        .dma_addr  (dma_addr),
        .dma_rdata (dma_rdata)
    );

`ifdef CPU_BUS_OPEN_BUS_EN
    logic [7:0] open_bus_q, open_bus_d;

    always_comb begin
        drive_en  = 1'b0;
        drive_val = cpu_rdata;
        if (cpu_rd) begin
            drive_en = 1'b1;
            if (!ram_hit) begin
                drive_val = open_bus_q;
            end
        end
    end

    // Capture whatever value is actually present on the bus this cycle
    always_comb begin
        open_bus_d = open_bus_q;
        if (write) begin
            open_bus_d = data;
        end else if (drive_en) begin
            open_bus_d = drive_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_bus_q <= 8'h00;
        end else begin
            open_bus_q <= open_bus_d;
        end
    end

    assign dma_byte = page_in_wram ? dma_rdata : open_bus_q;
`else
    always_comb begin
        drive_en  = cpu_rd & ram_hit;
        drive_val = cpu_rdata;
    end

    assign dma_byte = page_in_wram ? dma_rdata : 8'hFF;
`endif

    assign data = drive_en ? drive_val : 8'bz;

    // ------------------------------------------------------------------
    // DMA sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            page_q     <= 8'h00;
            idx_q      <= 8'h00;
            oam_data_q <= 8'h00;
            parity_q   <= 1'b0;
            align_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            oam_data_q <= oam_data_d;
            parity_q   <= parity_d;
            align_q    <= align_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        oam_data_d = oam_data_q;
        align_d    = align_q;
        parity_d   = ~parity_q;

        case (state_q)
            IDLE: begin
                if (dma_trig) begin
                    page_d  = data;
                    idx_d   = 8'h00;
                    align_d = parity_q;
                    state_d = HALT;
                end
            end
            HALT: begin
                state_d = align_q ? ALIGN : RD;
            end
            ALIGN: begin
                state_d = RD;
            end
            RD: begin
                oam_data_d = dma_byte;
                state_d    = WR;
            end
            WR: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == LAST_IDX) ? IDLE : RD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdy      = cpu_active;
    assign dma_busy = ~cpu_active;
    assign oam_we   = (state_q == WR);
    assign oam_data = oam_data_q;

endmodule : cpu_bus_responder
`default_nettype wire

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Target side of the CPU bus; the CPU drives addr/read/write and this block answers.
- Implements the 2 KB internal work RAM at $0000-$1FFF, with mirroring every $0800.
- Implements the OAM DMA register at $4014: a CPU write halts the CPU via rdy and streams one 256-byte page from work RAM to the PPU OAM write port.
- Sits beside CPU at the top level; the CPU testbench drives the CPU against it instead of the hand-driven data register.

Parameters:
- WRAM_AW, 11, work-RAM address width (2^WRAM_AW bytes, mirrored across $0000-$1FFF).
- DMA_REG_ADDR, 16'h4014, address of the OAM DMA trigger register.
- WRAM_TOP, 16'h1FFF, last address decoded as work RAM.

Ports:
- clk  in  1  system clock; one CPU cycle per clock.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  16  CPU address.
- data  inout  8  CPU data bus; driven only on a responding read, otherwise 8'bz.
- read  in  1  CPU read strobe, valid for the current cycle.
- write  in  1  CPU write strobe; data is sampled at posedge.
- rdy  out  1  CPU ready; low halts the CPU during DMA.
- oam_data  out  8  byte to PPU OAM ($2004 write path).
- oam_we  out  1  single-cycle OAM write strobe.
- dma_busy  out  1  high while DMA runs (debug/verification).

Behaviour:
- Reset values: rdy=1, oam_we=0, oam_data=0, dma_busy=0, data=z. Work-RAM contents are not reset.
- RAM decode: hit when addr<=WRAM_TOP; RAM index = addr[WRAM_AW-1:0].
- RAM read: combinational, zero wait states. data is driven with RAM[index] in the same cycle read&hit is asserted.
- RAM write: committed at posedge when write&hit; readable on the next cycle.
- read and write both high: write wins, data is not driven.
- Unmapped reads (not RAM, or $4014, which is write-only): data=z (see optional feature).
- Cycle parity: a 1-bit toggle flip-flop runs from reset (0 after reset, flips every clk).
- DMA FSM states: IDLE, HALT, ALIGN, RD, WR.
  - IDLE: on posedge with write & addr==DMA_REG_ADDR, latch page P=data and go to HALT. rdy drops the following cycle.
  - HALT: 1 dummy cycle. Go to ALIGN if the trigger write occurred on an odd-parity cycle, else go to RD.
  - ALIGN: 1 extra dummy cycle, then RD.
  - RD: fetch byte at {P,idx}.
    - P<=8'h1F: the byte comes from RAM[{P,idx}] with mirroring.
    - Any other page: the byte is 8'hFF.
    - Latch the byte into oam_data.
  - WR: oam_we=1 for exactly this cycle. idx increments mod 256. Go to IDLE after idx==8'hFF, else RD.
- Total stall: rdy low for 513 cycles (even trigger) or 514 cycles (odd trigger). rdy returns high in the cycle after the last WR.
- dma_busy equals ~rdy.
- During DMA, the CPU strobes read/write are ignored and data is never driven.
- A second $4014 write is impossible while halted; if one occurs anyway, it is ignored.
- rst_n asserted mid-DMA aborts immediately to reset values; idx and P are cleared.

Optional Feature:
- Macro: CPU_BUS_OPEN_BUS_EN.
- Defined:
  - An 8-bit open-bus latch captures every value on data (CPU-driven write or responder-driven read) at posedge.
  - Unmapped CPU reads drive the latch value instead of z.
  - DMA reads of pages >$1F also return the latch value instead of 8'hFF.
  - The latch resets to 8'h00.
- Undefined: no latch; unmapped reads leave data=z; out-of-range DMA pages give 8'hFF.

Decomposition:
- Package Enums gains:
  - dma_state_t (IDLE, HALT, ALIGN, RD, WR), logic[2:0];
  - constants WRAM_TOP_ADDR=16'h1FFF, OAM_DMA_ADDR=16'h4014, OAM_DMA_LEN=9'd256.
- Sub-module wram: 2^WRAM_AW x 8 array with async read and sync write, plus a second async read port for DMA. The top-level block keeps the decode, tristate, and DMA FSM.

Test Plan:
- Mirror: write $0005=8'h3C, then read $0805, $1005, $1805 -> each returns 8'h3C in the same cycle; read $2000 -> data=z.
- Write-then-read: write $07FF=8'hA5 at cycle n; read $07FF at n+1 -> 8'hA5.
- Even DMA: fill $0200-$02FF with idx^8'h5A, trigger $4014=8'h02 on an even cycle -> rdy low exactly 513 cycles, 256 oam_we pulses with oam_data=idx^8'h5A in order, rdy high afterwards.
- Odd DMA: same trigger issued on an odd cycle -> rdy low exactly 514 cycles; the first oam_we comes one cycle later than in the even case.
- Out-of-range page: $4014=8'h80 -> 256 writes of 8'hFF (CPU_BUS_OPEN_BUS_EN undefined).
- Reset mid-DMA: deassert rst_n during the 100th WR -> rdy=1, oam_we=0, dma_busy=0 immediately. A new $4014 write after reset release starts again from idx=0.
